// File: rtl/wdt_multi.sv
// Multi-channel watchdog: a shared prescaler tick drives each channel through
// COUNT -> GRACE -> BITE, with optional windowed kicks and a sticky reset request.
module wdt_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRE_W   = 8,
    parameter int GRACE_W = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          pre_we,
    input  logic [PRE_W-1:0]                              pre_val,
    input  logic                                          cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic                                          cfg_en,
    input  logic [CNT_W-1:0]                              cfg_timeout,
    input  logic [CNT_W-1:0]                              cfg_window,
    input  logic [GRACE_W-1:0]                            cfg_grace,
    input  logic [NUM_CH-1:0]                             kick,
    input  logic [NUM_CH-1:0]                             clr,
    output logic [NUM_CH-1:0]                             wto_irq,
    output logic                                          wdt_rst_req,
    output logic [2*NUM_CH-1:0]                           ch_state
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        GRACE = 2'd2,
        BITE  = 2'd3
    } state_t;

    logic [PRE_W-1:0]  pre_val_q;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic              cfg_ok;
    logic [NUM_CH-1:0] bite_d;

    // A prescaler write restarts the phase, so no tick is issued in that cycle.
    assign tick   = !pre_we && (pre_cnt == pre_val_q);
    assign cfg_ok = (int'(cfg_ch) < NUM_CH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_val_q <= '0;
            pre_cnt   <= '0;
        end else if (pre_we) begin
            pre_val_q <= pre_val;
            pre_cnt   <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else if (pre_cnt != '1) begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t             state_q, state_d;
        logic [CNT_W-1:0]   count_q, count_d, timeout_q, window_q;
        logic [GRACE_W-1:0] gcnt_q, gcnt_d, grace_q;
        logic [CNT_W:0]     count_inc;
        logic [GRACE_W:0]   gcnt_inc;
        logic               sel, kick_ok, irq_d, irq_q;

        assign sel       = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));
        assign count_inc = {1'b0, count_q} + (CNT_W+1)'(1);
        assign gcnt_inc  = {1'b0, gcnt_q} + (GRACE_W+1)'(1);
        assign kick_ok   = (window_q == '0) || (count_q >= window_q);

        // Decisions use the configuration held before this cycle's write.
        always_comb begin
            state_d = state_q;
            count_d = count_q;
            gcnt_d  = gcnt_q;
            irq_d   = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (sel && cfg_en) begin
                        state_d = COUNT;
                        count_d = '0;
                    end
                end
                COUNT: begin
                    if (sel && !cfg_en) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else if (kick[i] && kick_ok) begin
                        count_d = '0;
                    end else if (kick[i] || (tick && (count_inc >= {1'b0, timeout_q}))) begin
                        state_d = GRACE;
                        gcnt_d  = '0;
                        irq_d   = 1'b1;
                    end else if (tick && !count_inc[CNT_W]) begin
                        count_d = count_inc[CNT_W-1:0];
                    end
                end
                GRACE: begin
                    if (sel && !cfg_en) begin
                        state_d = IDLE;
                        gcnt_d  = '0;
                    end else if (kick[i]) begin
                        state_d = COUNT;
                        count_d = '0;
                    end else if (tick && (gcnt_inc >= {1'b0, grace_q})) begin
                        state_d = BITE;
                    end else if (tick && !gcnt_inc[GRACE_W]) begin
                        gcnt_d = gcnt_inc[GRACE_W-1:0];
                    end
                end
                BITE: begin
                    if (clr[i]) begin
                        state_d = IDLE;
                        count_d = '0;
                        gcnt_d  = '0;
                    end
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                count_q   <= '0;
                gcnt_q    <= '0;
                irq_q     <= 1'b0;
                timeout_q <= '0;
                window_q  <= '0;
                grace_q   <= '0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                gcnt_q  <= gcnt_d;
                irq_q   <= irq_d;
                if (sel) begin
                    timeout_q <= cfg_timeout;
                    window_q  <= cfg_window;
                    grace_q   <= cfg_grace;
                end
            end
        end

        assign wto_irq[i]         = irq_q;
        assign ch_state[2*i +: 2] = state_q;
        assign bite_d[i]          = (state_d == BITE);
    end

    // Built from next state so the request follows BITE entry/exit on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_rst_req <= 1'b0;
        end else begin
            wdt_rst_req <= |bite_d;
        end
    end

endmodule

// File: doc/wdt_multi.md
Name: wdt_multi

Overview:
Parametrised multi-channel watchdog timer, successor to the single-channel WDT. Each of NUM_CH channels has its own timeout, window and enable, all counted on a shared programmable prescaler tick. Escalates in two stages per channel: an interrupt pulse, then a grace period, then a sticky reset request. Sits on the peripheral side of the SoC; all inputs are synchronous to clk, so no CDC stage exists inside.

Parameters:
NUM_CH, 4, number of independent watchdog channels (1..16)
CNT_W, 32, width of per-channel tick counter, timeout and window values
PRE_W, 8, width of shared prescaler
GRACE_W, 8, width of per-channel grace-period counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
pre_we  in  1  write enable for prescaler value
pre_val  in  PRE_W  prescaler value; tick every pre_val+1 cycles
cfg_we  in  1  channel configuration write strobe
cfg_ch  in  $clog2(NUM_CH)  channel addressed by cfg_we
cfg_en  in  1  channel enable
cfg_timeout  in  CNT_W  ticks to expiry
cfg_window  in  CNT_W  earliest legal kick count (0 = no window)
cfg_grace  in  GRACE_W  ticks between interrupt and reset request
kick  in  NUM_CH  per-channel service pulse
clr  in  NUM_CH  per-channel clear of reset request
wto_irq  out  NUM_CH  one-cycle expiry/window-violation pulse
wdt_rst_req  out  1  OR of all channels in BITE; level
ch_state  out  2*NUM_CH  per-channel state code, channel i at [2i+1:2i]

Behaviour:
- Reset: all channels IDLE, counters 0, config regs 0, pre_val 0, wto_irq 0, wdt_rst_req 0, ch_state 0.
- Prescaler: pre_cnt increments each cycle; when pre_cnt == pre_val, tick = 1 for that cycle and pre_cnt <= 0. pre_val = 0 -> tick every cycle. pre_we loads pre_val and clears pre_cnt; no tick in the cycle of the write.
- Config write (cfg_we): loads timeout/window/grace/en for cfg_ch, ignored if cfg_ch >= NUM_CH. Write with cfg_en = 1 to an IDLE channel -> COUNT next cycle, count = 0. Write with cfg_en = 0 -> IDLE from COUNT or GRACE; ignored in BITE (only clr leaves BITE). Write in COUNT/GRACE with cfg_en = 1 updates values without clearing count.
- States (code): IDLE 0, COUNT 1, GRACE 2, BITE 3.
- COUNT: on tick, count <= count + 1. Expiry when tick and count+1 >= timeout (timeout 0 -> first tick). Expiry -> GRACE, wto_irq[i] = 1 for exactly one cycle (the cycle after the expiring edge), grace count = 0.
- Kick in COUNT: if window == 0 or count >= window -> count <= 0, stay COUNT. If count < window -> window violation: identical to expiry (-> GRACE, irq pulse).
- Kick and expiring tick in same cycle: legal kick wins (count <= 0, no irq); illegal kick -> single irq pulse, not two.
- GRACE: grace count increments on tick; kick (window not checked) -> COUNT, count <= 0. Tick with grace count+1 >= cfg_grace -> BITE (cfg_grace 0 -> BITE on first tick).
- BITE: wdt_rst_req = 1 (registered, asserted the cycle after entry). Kick ignored. clr[i] -> IDLE, channel stays disabled until rewritten with cfg_en = 1.
- clr in any state other than BITE ignored.
- Counters saturate at all-ones and never wrap.
- rst asserted mid-operation: immediate return to reset values, independent of clk.
- Outputs wto_irq, wdt_rst_req, ch_state are registered.

Test Plan:
- pre_val = 0, ch0 timeout = 5, window = 0, grace = 3, no kicks -> wto_irq[0] pulses once, 5 cycles after enable; wdt_rst_req rises 3 cycles later; ch_state[1:0] = 3.
- pre_val = 3, ch1 timeout = 4 -> expiry after 16 cycles; pre_we mid-count restarts the prescale phase.
- ch2 window = 4, timeout = 10; kick at count 2 -> immediate irq, GRACE; kick at count 6 -> count resets, no irq.
- Kick in GRACE -> COUNT with count 0, wdt_rst_req stays 0; then clr in BITE -> IDLE, wdt_rst_req drops the next cycle.
- Legal kick on the same cycle as the expiring tick -> no irq; two channels expiring together -> both irq bits set in the same cycle.
- Async rst pulse between clk edges during GRACE -> all outputs 0 immediately; cfg_we with cfg_en = 0 in BITE ignored.
